// File: rtl/cen_uart_pkg.sv
// cen_uart shared constants.
// FSM state encodings used by both the rx and tx machines.
package cen_uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/cen_uart_rx.sv
// cen_uart receive path.
// 2-flop synchronizer and 8N1 receive FSM.
module cen_uart_rx
  import cen_uart_pkg::*;
#(
  parameter logic [4:0] UART_DIVIDER = 5'd23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen_i,
  input  logic       sub_tick_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       done_o,
  output logic       error_o
);

  localparam logic [5:0] HALF =
    ({1'b0, UART_DIVIDER} + 6'd1) >> 1;
  localparam logic [4:0] HALF_M1 =
    5'(HALF - 6'd1);

  logic [1:0] sync_q;
  logic       rx_s;

  logic [1:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       armed_q, armed_d;

  assign rx_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    armed_d = armed_q;
    if (cen_i && rx_s)
      armed_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (cen_i && !rx_s && armed_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (sub_tick_i) begin
          if (cnt_q == HALF_M1) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (sub_tick_i) begin
          if (cnt_q == UART_DIVIDER) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7)
              state_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_STOP: begin
        if (sub_tick_i) begin
          if (cnt_q == UART_DIVIDER) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            if (rx_s) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              err_d   = 1'b1;
              // hold off restart until the line has recovered
              armed_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      armed_q <= armed_d;
    end
  end

  assign data_o  = data_q;
  assign done_o  = done_q;
  assign error_o = err_q;

endmodule

// File: rtl/cen_uart.sv
// cen_uart: 8N1 UART advanced by a clock enable.
// Holds the prescaler and transmit FSM; receive path is a sub-module.
module cen_uart
  import cen_uart_pkg::*;
#(
  parameter logic [4:0] CLK_DIVIDER  = 5'd3,
  parameter logic [4:0] UART_DIVIDER = 5'd23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_error,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy,
  output logic       tx_done
);

  logic [4:0] presc_q;
  logic       sub_tick;

  assign sub_tick = cen && (presc_q == CLK_DIVIDER);

  always_ff @(posedge clk) begin
    if (rst)
      presc_q <= '0;
    else if (cen)
      presc_q <= sub_tick ? 5'd0 : presc_q + 5'd1;
  end

  logic [1:0] tx_state_q, tx_state_d;
  logic [4:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_done_q, tx_done_d;
  logic       tx_line_q, tx_line_d;
  logic       tx_bit_end;

  assign tx_bit_end =
    sub_tick && (tx_cnt_q == UART_DIVIDER);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = 1'b0;
    if (tx_state_q != ST_IDLE && sub_tick)
      tx_cnt_d = tx_bit_end ? 5'd0 : tx_cnt_q + 5'd1;
    unique case (tx_state_q)
      ST_IDLE: begin
        // a write coincident with tx_done is dropped
        if (cen && tx_wr && !tx_done_q) begin
          tx_state_d = ST_START;
          tx_shift_d = tx_data;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end
      end
      ST_START: begin
        if (tx_bit_end)
          tx_state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7)
            tx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tx_bit_end) begin
          tx_state_d = ST_IDLE;
          tx_done_d  = 1'b1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_line_d = 1'b1;
    if (tx_state_d == ST_START)
      tx_line_d = 1'b0;
    else if (tx_state_d == ST_DATA)
      tx_line_d = tx_shift_d[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_done_q  <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_done_q  <= tx_done_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign uart_tx = tx_line_q;
  assign tx_busy = (tx_state_q != ST_IDLE);
  assign tx_done = tx_done_q;

  cen_uart_rx #(
    .UART_DIVIDER(UART_DIVIDER)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .cen_i     (cen),
    .sub_tick_i(sub_tick),
    .rx_i      (uart_rx),
    .data_o    (rx_data),
    .done_o    (rx_done),
    .error_o   (rx_error)
  );

endmodule

// File: tb/tb_cen_uart.sv
// Directed self-checking bench for cen_uart.
// Fast instance (BP=4 clks) plus a default-parameter instance.
module tb_cen_uart;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cen_f;
  logic       loop_f;
  logic       rxdrv_f;
  logic       rx_f;
  logic       tx_f;
  logic [7:0] rxdata_f;
  logic       rxdone_f;
  logic       rxerr_f;
  logic [7:0] txdata_f;
  logic       txwr_f;
  logic       busy_f;
  logic       txdone_f;

  logic       cen_s;
  logic       tx_s;
  logic [7:0] rxdata_s;
  logic       rxdone_s;
  logic       rxerr_s;
  logic [7:0] txdata_s;
  logic       txwr_s;
  logic       busy_s;
  logic       txdone_s;

  assign rx_f = loop_f ? tx_f : rxdrv_f;

  cen_uart #(
    .CLK_DIVIDER (5'd0),
    .UART_DIVIDER(5'd3)
  ) u_fast (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen_f),
    .uart_rx (rx_f),
    .uart_tx (tx_f),
    .rx_data (rxdata_f),
    .rx_done (rxdone_f),
    .rx_error(rxerr_f),
    .tx_data (txdata_f),
    .tx_wr   (txwr_f),
    .tx_busy (busy_f),
    .tx_done (txdone_f)
  );

  cen_uart u_slow (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen_s),
    .uart_rx (tx_s),
    .uart_tx (tx_s),
    .rx_data (rxdata_s),
    .rx_done (rxdone_s),
    .rx_error(rxerr_s),
    .tx_data (txdata_s),
    .tx_wr   (txwr_s),
    .tx_busy (busy_s),
    .tx_done (txdone_s)
  );

  int nd_f = 0, ne_f = 0, nt_f = 0;
  int nd_s = 0, ne_s = 0;

  always @(negedge clk) begin
    if (rxdone_f) nd_f <= nd_f + 1;
    if (rxerr_f)  ne_f <= ne_f + 1;
    if (txdone_f) nt_f <= nt_f + 1;
    if (rxdone_s) nd_s <= nd_s + 1;
    if (rxerr_s)  ne_s <= ne_s + 1;
  end

  initial begin
    int ph;
    ph = 0;
    cen_s = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cen_s = (ph == 2);
      ph = (ph + 1) % 3;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %0h want %0h",
                tag, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_f(input logic [9:0] f);
    for (int i = 0; i < 10; i++) begin
      rxdrv_f = f[i];
      repeat (4) step();
    end
    rxdrv_f = 1'b1;
  endtask

  initial begin
    logic [9:0] frame;
    int cnt, t0, d0, e0;
    rst = 1'b1;
    cen_f = 1'b1;
    loop_f = 1'b0;
    rxdrv_f = 1'b1;
    txdata_f = 8'h00;
    txwr_f = 1'b0;
    txdata_s = 8'h00;
    txwr_s = 1'b0;
    repeat (3) step();
    chk("rst_uart_tx", tx_f, 1);
    chk("rst_tx_busy", busy_f, 0);
    chk("rst_tx_done", txdone_f, 0);
    chk("rst_rx_done", rxdone_f, 0);
    chk("rst_rx_error", rxerr_f, 0);
    chk("rst_rx_data", rxdata_f, 8'h00);
    rst = 1'b0;
    repeat (3) step();

    // A5 frame with an ignored mid-frame write
    frame = {1'b1, 8'hA5, 1'b0};
    txdata_f = 8'hA5;
    txwr_f = 1'b1;
    step();
    txwr_f = 1'b0;
    chk("tx_busy_start", busy_f, 1);
    t0 = nt_f;
    cnt = 0;
    while (busy_f && cnt < 100) begin
      if (cnt % 4 == 1)
        chk($sformatf("tx_bit%0d", cnt / 4),
            tx_f, frame[cnt / 4]);
      if (cnt == 10) begin
        txwr_f = 1'b1;
        txdata_f = 8'h00;
      end else begin
        txwr_f = 1'b0;
      end
      step();
      cnt++;
    end
    chk("tx_busy_len", cnt, 40);
    chk("tx_done_pulse", txdone_f, 1);

    txwr_f = 1'b1;
    txdata_f = 8'h3C;
    loop_f = 1'b1;
    step();
    chk("tx_wr_on_done_ignored", busy_f, 0);
    chk("tx_done_width", txdone_f, 0);
    chk("tx_done_once", nt_f - t0, 1);
    d0 = nd_f;
    e0 = ne_f;
    step();
    txwr_f = 1'b0;
    chk("tx_wr_after_done", busy_f, 1);

    repeat (60) step();
    chk("loop_rx_done_cnt", nd_f - d0, 1);
    chk("loop_rx_data", rxdata_f, 8'h3C);
    chk("loop_rx_err_cnt", ne_f - e0, 0);

    // framing error then a valid byte
    loop_f = 1'b0;
    repeat (8) step();
    d0 = nd_f;
    e0 = ne_f;
    send_f({1'b0, 8'hFF, 1'b0});
    repeat (20) step();
    chk("ferr_err_cnt", ne_f - e0, 1);
    chk("ferr_done_cnt", nd_f - d0, 0);
    chk("ferr_rx_data_kept", rxdata_f, 8'h3C);
    d0 = nd_f;
    e0 = ne_f;
    send_f({1'b1, 8'h55, 1'b0});
    repeat (20) step();
    chk("after_ferr_done_cnt", nd_f - d0, 1);
    chk("after_ferr_data", rxdata_f, 8'h55);
    chk("after_ferr_err_cnt", ne_f - e0, 0);

    // short low glitch
    d0 = nd_f;
    e0 = ne_f;
    rxdrv_f = 1'b0;
    step();
    rxdrv_f = 1'b1;
    repeat (20) step();
    chk("glitch_done_cnt", nd_f - d0, 0);
    chk("glitch_err_cnt", ne_f - e0, 0);

    // reset in mid-transmission
    txdata_f = 8'hA5;
    txwr_f = 1'b1;
    step();
    txwr_f = 1'b0;
    repeat (10) step();
    chk("mid_busy", busy_f, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_uart_tx", tx_f, 1);
    chk("mid_rst_busy", busy_f, 0);
    chk("mid_rst_rx_data", rxdata_f, 8'h00);
    rst = 1'b0;
    repeat (10) step();

    // default dividers, cen every third clk
    d0 = nd_s;
    e0 = ne_s;
    txdata_s = 8'h41;
    txwr_s = 1'b1;
    cnt = 0;
    while (!busy_s && cnt < 10) begin
      step();
      cnt++;
    end
    txwr_s = 1'b0;
    chk("slow_accept", busy_s, 1);
    cnt = 0;
    while (tx_s == 1'b0 && cnt < 600) begin
      step();
      cnt++;
    end
    cnt = 0;
    while (tx_s == 1'b1 && cnt < 600) begin
      step();
      cnt++;
    end
    chk("slow_bit_time", cnt, 288);
    cnt = 0;
    while (nd_s == d0 && cnt < 4000) begin
      step();
      cnt++;
    end
    step();
    chk("slow_rx_done_cnt", nd_s - d0, 1);
    chk("slow_rx_data", rxdata_s, 8'h41);
    chk("slow_rx_err_cnt", ne_s - e0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cen_uart.md
Name: cen_uart

Overview:
- 8N1 asynchronous serial transmitter/receiver with a parallel byte interface, clocked by `clk` and advanced only on a clock-enable strobe `cen`.
- Used as a debug/console port beside the main Z80 CPU; the CPU writes bytes to send and polls for received bytes.
- Baud rate comes from two cascaded integer dividers applied to the `cen` rate.

Parameters:
- CLK_DIVIDER, 5'd3: prescaler terminal count; one sub-tick every CLK_DIVIDER+1 `cen` pulses.
- UART_DIVIDER, 5'd23: sub-ticks per bit, minus one.
- Derived: bit period BP = (CLK_DIVIDER+1)*(UART_DIVIDER+1) `cen` pulses; defaults give 96.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- cen  in  1  clock enable; all timing and state advance only when cen=1.
- uart_rx  in  1  serial input; idle high; asynchronous to clk.
- uart_tx  out  1  serial output; high when idle.
- rx_data  out  8  last correctly received byte.
- rx_done  out  1  one-clk pulse: new byte valid on rx_data.
- rx_error  out  1  one-clk pulse: framing error (stop bit low).
- tx_data  in  8  byte to transmit.
- tx_wr  in  1  write strobe; sampled only when cen=1.
- tx_busy  out  1  transmitter active.
- tx_done  out  1  one-clk pulse at end of stop bit.

Behaviour:
- Reset values (`rst` high at a clk edge), regardless of any frame in flight:
  - uart_tx=1, tx_busy=0, tx_done=0, rx_done=0, rx_error=0, rx_data=8'h00.
  - All counters cleared; both FSMs return to IDLE.
- Timebase:
  - Free-running prescaler 0..CLK_DIVIDER steps on cen.
  - Rx and tx each keep their own bit counter of 0..UART_DIVIDER sub-ticks.
  - Each bit counter restarts at 0 when its FSM leaves IDLE, so timing is frame-relative.
  - Phase error at frame start is therefore at most one sub-tick.
- Tx FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - In IDLE, tx_wr=1 with cen=1 latches tx_data; tx_busy=1 and uart_tx=0 from the next clk.
  - Each state lasts exactly BP cen pulses. STOP drives 1.
  - At the end of STOP: tx_busy=0 and tx_done=1 for one clk; back in IDLE.
  - tx_wr while busy is ignored, with no queuing.
  - tx_wr in the same clk as the tx_done pulse is ignored; it is accepted from the next cen onward.
- Rx input path: 2-flop synchronizer on uart_rx (runs every clk). The FSM uses the synchronized value on cen.
- Rx FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a low level seen on cen enters START.
  - START: wait BP/2 cen pulses (integer division). If the line is high there, it is a false start: return to IDLE with no pulse. Otherwise go to DATA.
  - DATA: sample every BP cen pulses thereafter. 8 bits are shifted LSB first.
  - STOP: sample after one more BP.
    - Stop bit = 1: rx_data updated, rx_done=1 for one clk.
    - Stop bit = 0: rx_error=1 for one clk, rx_data unchanged.
  - Either way the FSM returns to IDLE.
  - After a framing error, IDLE does not re-enter START until the line has been seen high on at least one cen.
  - Rx and tx are fully independent; simultaneous operation is required.
- rx_done, rx_error and tx_done are pulses exactly one clk wide, even when cen is high on consecutive clks.

Decomposition:
- No shared package is needed. Parameters are local, and FSM state encodings are localparams.
- One sub-module is natural, `cen_uart_rx`, holding the synchronizer and the rx FSM.
- The tx path and the prescaler stay in the top module.

Test Plan:
- Tx frame (CLK_DIVIDER=0, UART_DIVIDER=3, cen every clk): tx_wr=1 with tx_data=8'hA5.
  - uart_tx shows 0,1,0,1,0,0,1,0,1,1, each bit lasting 4 clks.
  - tx_busy is high for 40 clks, then tx_done pulses once.
- Tx while busy: a second tx_wr with tx_data=8'h00 mid-frame is ignored. The line still carries 8'hA5; only one tx_done.
- Rx loopback (uart_rx tied to uart_tx): send 8'h3C. rx_done pulses once with rx_data=8'h3C and rx_error=0.
- Framing error: drive a 10-bit frame carrying 8'hFF with the stop bit 0.
  - rx_error pulses once; rx_done stays 0; rx_data keeps its old value.
  - A following valid 8'h55 is still received.
- Glitch and reset:
  - A 1-bit-period/4 low glitch on uart_rx produces no rx_done and no rx_error.
  - Asserting rst mid-transmission returns uart_tx=1 and tx_busy=0 on the next clk.
- Default parameters with cen every 3rd clk: the tx bit time is 96 cen = 288 clks, and an 8'h41 loopback is received correctly.
